// File: rtl/uart_pkg.sv
// Shared UART definitions: baud timing constants and the TX arbiter state encoding.
package uart_pkg;

  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int BAUD_RATE   = 9600;
  // One bit time in clocks; doubles as the default inter-frame idle gap.
  localparam int BIT_CYCLES  = CLK_FREQ_HZ / BAUD_RATE;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arbState_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from the
// index after i_last, wrapping around. Shared by the TX arbiter and future RX dispatch.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan from farthest to nearest so the nearest candidate overwrites the rest.
  always_comb begin
    int cand;
    cand    = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(i_last) + k) % NUM_REQ;
      if (i_req[IDX_W'(cand)]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers,
// with a completion watchdog and an enforced idle gap between frames.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int GAP_CYCLES     = BIT_CYCLES,
  parameter  int TIMEOUT_CYCLES = 1200,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_uart_start,
  output logic [7:0]           o_uart_tx_in,
  input  logic                 i_uart_tx_done,
  output logic                 o_busy,
  output logic [IDX_W-1:0]     o_grant_id,
  output logic                 o_timeout_err
);

  localparam int CNT_MAX = maxInt(GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX_RST = IDX_W'(NUM_REQ - 1);

  arbState_t            r_state;
  arbState_t            w_nextState;
  logic [CNT_W-1:0]     r_timer;
  logic [CNT_W-1:0]     w_nextTimer;
  logic                 w_grant;
  logic                 w_abort;
  logic                 w_pickValid;
  logic [IDX_W-1:0]     w_pickIdx;
  logic [7:0]           w_pickData;
  logic [NUM_REQ-1:0]   w_pickOneHot;

  logic [NUM_REQ-1:0]   r_reqReady;
  logic                 r_start;
  logic [7:0]           r_txIn;
  logic                 r_busy;
  logic [IDX_W-1:0]     r_grantId;
  logic                 r_timeoutErr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rrPick (
    .i_req   (i_req_valid),
    .i_last  (r_grantId),
    .o_valid (w_pickValid),
    .o_idx   (w_pickIdx)
  );

  always_comb begin
    w_pickData   = '0;
    w_pickOneHot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pickIdx == IDX_W'(i)) begin
        w_pickData      = i_req_data[i*8 +: 8];
        w_pickOneHot[i] = 1'b1;
      end
    end
  end

  // One timer serves both the watchdog and the gap; it restarts at 1 on each
  // entry so WAIT_DONE and GAP each last exactly their configured count.
  always_comb begin
    w_nextState = r_state;
    w_nextTimer = r_timer;
    w_grant     = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nextTimer = '0;
        if (w_pickValid) begin
          w_grant     = 1'b1;
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_nextState = ST_WAIT_DONE;
        w_nextTimer = CNT_ONE;
      end
      ST_WAIT_DONE: begin
        if (i_uart_tx_done) begin
          w_nextState = ST_GAP;
          w_nextTimer = CNT_ONE;
        end else if (r_timer >= TIMEOUT_LAST) begin
          w_abort     = 1'b1;
          w_nextState = ST_GAP;
          w_nextTimer = CNT_ONE;
        end else if (r_timer < CNT_SAT) begin
          w_nextTimer = r_timer + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (r_timer >= GAP_LAST) begin
          w_nextState = ST_IDLE;
          w_nextTimer = '0;
        end else if (r_timer < CNT_SAT) begin
          w_nextTimer = r_timer + CNT_ONE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextTimer = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_nextState;
      r_timer <= w_nextTimer;
    end
  end

  // All outputs are registered so no input reaches an output combinationally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_reqReady   <= '0;
      r_start      <= 1'b0;
      r_txIn       <= 8'h00;
      r_busy       <= 1'b0;
      r_grantId    <= LAST_IDX_RST;
      r_timeoutErr <= 1'b0;
    end else begin
      r_reqReady   <= w_grant ? w_pickOneHot : '0;
      r_start      <= w_grant;
      r_busy       <= (w_nextState != ST_IDLE);
      r_timeoutErr <= w_abort;
      if (w_grant) begin
        r_grantId <= w_pickIdx;
        r_txIn    <= w_pickData;
      end
    end
  end

  assign o_req_ready   = r_reqReady;
  assign o_uart_start  = r_start;
  assign o_uart_tx_in  = r_txIn;
  assign o_busy        = r_busy;
  assign o_grant_id    = r_grantId;
  assign o_timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 104-cycle gap,
// 1200-cycle watchdog) with hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int GAP     = 104;
  localparam int TMO     = 1200;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqReady;
  logic        uartStart;
  logic [7:0]  uartTxIn;
  logic        uartTxDone;
  logic        busy;
  logic [1:0]  grantId;
  logic        timeoutErr;

  int   numChecks = 0;
  int   numFails  = 0;
  logic seenReady;
  logic seenErr;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (reqValid),
    .i_req_data     (reqData),
    .o_req_ready    (reqReady),
    .o_uart_start   (uartStart),
    .o_uart_tx_in   (uartTxIn),
    .i_uart_tx_done (uartTxDone),
    .o_busy         (busy),
    .o_grant_id     (grantId),
    .o_timeout_err  (timeoutErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n clocks, landing 1 ns after the edge; sticky monitors catch stray pulses.
  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      seenReady = seenReady | (|reqReady);
      seenErr   = seenErr | timeoutErr;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] idx, input logic [7:0] data);
    reqData[{idx, 3'b000} +: 8] = data;
    reqValid[idx] = 1'b1;
  endtask

  // Starts in an IDLE cycle with the winner pending; ends in the next IDLE cycle.
  task automatic serveFrame(input logic [1:0] idx, input logic [7:0] data,
                            input logic [3:0] raiseMask, input string tag);
    stepClock(1);
    checkOutput({tag, "_ready"},   32'(reqReady),  32'(4'b0001 << idx));
    checkOutput({tag, "_txIn"},    32'(uartTxIn),  32'(data));
    checkOutput({tag, "_start"},   32'(uartStart), 32'd1);
    checkOutput({tag, "_grantId"}, 32'(grantId),   32'(idx));
    reqValid[idx] = 1'b0;
    reqValid = reqValid | raiseMask;
    stepClock(1);
    checkOutput({tag, "_readyDrop"}, 32'(reqReady),  32'd0);
    checkOutput({tag, "_startDrop"}, 32'(uartStart), 32'd0);
    checkOutput({tag, "_busyWait"},  32'(busy),      32'd1);
    stepClock(3);
    uartTxDone = 1'b1;
    stepClock(1);
    uartTxDone = 1'b0;
    stepClock(GAP - 1);
    checkOutput({tag, "_busyGapEnd"}, 32'(busy),     32'd1);
    checkOutput({tag, "_txInHeld"},   32'(uartTxIn), 32'(data));
    stepClock(1);
    checkOutput({tag, "_busyIdle"},   32'(busy),     32'd0);
  endtask

  initial begin
    int  waited;
    bit  hit;
    rst        = 1'b1;
    reqValid   = '0;
    reqData    = '0;
    uartTxDone = 1'b0;
    seenReady  = 1'b0;
    seenErr    = 1'b0;

    stepClock(2);
    checkOutput("rst_ready",   32'(reqReady),   32'd0);
    checkOutput("rst_start",   32'(uartStart),  32'd0);
    checkOutput("rst_txIn",    32'(uartTxIn),   32'd0);
    checkOutput("rst_busy",    32'(busy),       32'd0);
    checkOutput("rst_grantId", 32'(grantId),    32'd3);
    checkOutput("rst_err",     32'(timeoutErr), 32'd0);
    rst = 1'b0;
    stepClock(1);

    applyStimulus(2'd2, 8'hA5);
    serveFrame(2'd2, 8'hA5, 4'b0000, "single");

    rst = 1'b1;
    stepClock(1);
    rst = 1'b0;
    stepClock(1);
    applyStimulus(2'd0, 8'h10);
    applyStimulus(2'd1, 8'h11);
    applyStimulus(2'd2, 8'h12);
    applyStimulus(2'd3, 8'h13);
    serveFrame(2'd0, 8'h10, 4'b0000, "all0");
    serveFrame(2'd1, 8'h11, 4'b0000, "all1");
    serveFrame(2'd2, 8'h12, 4'b0000, "all2");
    serveFrame(2'd3, 8'h13, 4'b0000, "all3");

    reqData[7:0]   = 8'h30;
    reqData[31:24] = 8'h33;
    applyStimulus(2'd2, 8'h22);
    serveFrame(2'd2, 8'h22, 4'b1001, "fair2");
    serveFrame(2'd3, 8'h33, 4'b0000, "fair3");
    serveFrame(2'd0, 8'h30, 4'b0000, "fair0");

    applyStimulus(2'd1, 8'h5C);
    stepClock(1);
    checkOutput("wdog_start",   32'(uartStart), 32'd1);
    checkOutput("wdog_grantId", 32'(grantId),   32'd1);
    reqValid[1] = 1'b0;
    applyStimulus(2'd3, 8'h77);
    waited = 0;
    hit    = 1'b0;
    while (!hit && waited < 1300) begin
      stepClock(1);
      waited++;
      if (timeoutErr) hit = 1'b1;
    end
    checkOutput("wdog_latency", 32'(waited), 32'd1201);
    checkOutput("wdog_busyGap", 32'(busy),   32'd1);
    stepClock(1);
    checkOutput("wdog_pulseWidth", 32'(timeoutErr), 32'd0);
    stepClock(GAP - 2);
    checkOutput("wdog_busyGapEnd", 32'(busy), 32'd1);
    stepClock(1);
    checkOutput("wdog_busyIdle", 32'(busy), 32'd0);
    serveFrame(2'd3, 8'h77, 4'b0000, "postWdog");

    applyStimulus(2'd2, 8'h3C);
    stepClock(1);
    checkOutput("rstMid_grantId", 32'(grantId), 32'd2);
    reqValid[2] = 1'b0;
    stepClock(5);
    checkOutput("rstMid_busyWait", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    checkOutput("rstMid_busy",    32'(busy),       32'd0);
    checkOutput("rstMid_start",   32'(uartStart),  32'd0);
    checkOutput("rstMid_ready",   32'(reqReady),   32'd0);
    checkOutput("rstMid_txIn",    32'(uartTxIn),   32'd0);
    checkOutput("rstMid_grantId", 32'(grantId),    32'd3);
    checkOutput("rstMid_err",     32'(timeoutErr), 32'd0);
    stepClock(1);
    rst = 1'b0;
    applyStimulus(2'd0, 8'h01);
    applyStimulus(2'd1, 8'h02);
    serveFrame(2'd0, 8'h01, 4'b0000, "rstWin0");

    stepClock(1);
    checkOutput("hold_grantId", 32'(grantId),  32'd1);
    checkOutput("hold_ready",   32'(reqReady), 32'd2);
    checkOutput("hold_txIn",    32'(uartTxIn), 32'h02);
    reqValid[1] = 1'b0;
    stepClock(1);
    seenReady  = 1'b0;
    seenErr    = 1'b0;
    uartTxDone = 1'b1;
    stepClock(3);
    uartTxDone = 1'b0;
    stepClock(5);
    uartTxDone = 1'b1;
    stepClock(1);
    uartTxDone = 1'b0;
    stepClock(GAP - 9);
    checkOutput("hold_busyGapEnd", 32'(busy), 32'd1);
    stepClock(1);
    checkOutput("hold_busyIdle", 32'(busy), 32'd0);
    stepClock(3);
    checkOutput("hold_stillIdle", 32'(busy),      32'd0);
    checkOutput("hold_noReady",   32'(seenReady), 32'd0);
    checkOutput("hold_noErr",     32'(seenErr),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
